// File: rtl/pulpino_boot_pkg.sv
// Shared constants and types for the PULPino reset/boot sequencer.
package pulpino_boot_pkg;

    typedef logic [2:0] boot_state_t;

    localparam boot_state_t ST_HOLD    = 3'd0;
    localparam boot_state_t ST_RELEASE = 3'd1;
    localparam boot_state_t ST_RUN     = 3'd2;
    localparam boot_state_t ST_HALT    = 3'd3;

    localparam logic [1:0] CAUSE_POR  = 2'd0;
    localparam logic [1:0] CAUSE_BTN  = 2'd1;
    localparam logic [1:0] CAUSE_JTAG = 2'd2;

    localparam logic [7:0] COUNT_MAX = 8'hFF;

    typedef struct packed {
        logic jtag;
        logic btn;
    } reset_req_t;

    // One counter serves both timed phases, so it is sized for the longer one.
    function automatic int cnt_width(input int hold_cycles, input int fetch_cycles);
        int longest;
        longest = (hold_cycles > fetch_cycles) ? hold_cycles : fetch_cycles;
        return (longest < 2) ? 1 : $clog2(longest);
    endfunction

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchronizer followed by a debounce counter: the output only
// follows the synchronized input after it has disagreed for DEBOUNCE_CYCLES edges.
module sync_debounce #(
    parameter int   DEBOUNCE_CYCLES = 250000,
    parameter logic RESET_VALUE     = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level
);

    localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          stable;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= {2{RESET_VALUE}};
        end else begin
            sync <= {sync[0], raw};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            stable <= RESET_VALUE;
        end else if (sync[1] == stable) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            stable <= sync[1];
            cnt    <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign level = stable;

endmodule

// File: rtl/pulpino_boot_ctrl.sv
// Reset and boot sequencer for PULPino: merges POR, button and JTAG resets and
// releases core reset, boot address and fetch enable in a fixed, timed order.
module pulpino_boot_ctrl
    import pulpino_boot_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDR_DEFAULT  = 32'h0000_8000,
    parameter logic [31:0] BOOT_ADDR_ALT      = 32'h0000_0000,
    parameter int          DEBOUNCE_CYCLES    = 250000,
    parameter int          RESET_HOLD_CYCLES  = 16,
    parameter int          FETCH_DELAY_CYCLES = 8
) (
    input  logic        CLOCK_50,
    input  logic        reset_n,
    input  logic        key_rst_n_i,
    input  logic        jtag_reset_i,
    input  logic        halt_req_i,
    input  logic        boot_sel_i,
    output logic        core_rst_n_o,
    output logic        fetch_enable_o,
    output logic [31:0] boot_addr_o,
    output logic [2:0]  state_o,
    output logic [1:0]  reset_cause_o,
    output logic [7:0]  reset_count_o
);

    localparam int CNT_W = cnt_width(RESET_HOLD_CYCLES, FETCH_DELAY_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(RESET_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] FETCH_LAST = CNT_W'(FETCH_DELAY_CYCLES - 1);

    logic [1:0]  jtag_sync;
    logic [1:0]  halt_sync;
    logic [1:0]  sel_sync;
    logic        key_level;
    reset_req_t  req;
    logic        por;
    logic        rq;

    boot_state_t      state;
    boot_state_t      state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             take_reset;
    logic             latch_boot;

    logic        core_rst_n;
    logic        fetch_en;
    logic [31:0] boot_addr;
    logic [1:0]  cause;
    logic [7:0]  count;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            jtag_sync <= 2'b00;
            halt_sync <= 2'b00;
            sel_sync  <= 2'b00;
        end else begin
            jtag_sync <= {jtag_sync[0], jtag_reset_i};
            halt_sync <= {halt_sync[0], halt_req_i};
            sel_sync  <= {sel_sync[0], boot_sel_i};
        end
    end

    sync_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RESET_VALUE     (1'b1)
    ) u_key_debounce (
        .clk   (CLOCK_50),
        .rst_n (reset_n),
        .raw   (key_rst_n_i),
        .level (key_level)
    );

    // por is high for the first edge only, so the hold window starts counting
    // once the request register carries a real sample of the synchronizers.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            req <= '0;
            por <= 1'b1;
        end else begin
            req.jtag <= jtag_sync[1];
            req.btn  <= ~key_level;
            por      <= 1'b0;
        end
    end

    assign rq = por | req.jtag | req.btn;

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        take_reset = 1'b0;
        latch_boot = 1'b0;
        case (state)
            ST_HOLD: begin
                if (rq) begin
                    cnt_nxt = '0;
                end else if (cnt == HOLD_LAST) begin
                    state_nxt  = ST_RELEASE;
                    cnt_nxt    = '0;
                    latch_boot = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                if (rq) begin
                    state_nxt  = ST_HOLD;
                    cnt_nxt    = '0;
                    take_reset = 1'b1;
                end else if (cnt == FETCH_LAST) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (rq) begin
                    state_nxt  = ST_HOLD;
                    cnt_nxt    = '0;
                    take_reset = 1'b1;
                end else if (halt_sync[1]) begin
                    state_nxt = ST_HALT;
                end
            end
            ST_HALT: begin
                if (rq) begin
                    state_nxt  = ST_HOLD;
                    cnt_nxt    = '0;
                    take_reset = 1'b1;
                end else if (!halt_sync[1]) begin
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                state_nxt = ST_HOLD;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they switch on the same edge as the FSM.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_HOLD;
            cnt        <= '0;
            core_rst_n <= 1'b0;
            fetch_en   <= 1'b0;
            boot_addr  <= BOOT_ADDR_DEFAULT;
            cause      <= CAUSE_POR;
            count      <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            core_rst_n <= (state_nxt != ST_HOLD);
            fetch_en   <= (state_nxt == ST_RUN);
            if (latch_boot) begin
                boot_addr <= sel_sync[1] ? BOOT_ADDR_ALT : BOOT_ADDR_DEFAULT;
            end
            if (take_reset) begin
                cause <= req.jtag ? CAUSE_JTAG : CAUSE_BTN;
                if (count != COUNT_MAX) begin
                    count <= count + 8'd1;
                end
            end
        end
    end

    assign core_rst_n_o   = core_rst_n;
    assign fetch_enable_o = fetch_en;
    assign boot_addr_o    = boot_addr;
    assign state_o        = state;
    assign reset_cause_o  = cause;
    assign reset_count_o  = count;

endmodule

// File: tb/tb_pulpino_boot_ctrl.sv
// Self-checking bench for pulpino_boot_ctrl: hand-computed vectors and sequences
// plus randomized stimulus checked every cycle against a behavioural model.
module tb_pulpino_boot_ctrl;

    localparam int DEB   = 4;
    localparam int HOLD  = 16;
    localparam int FETCH = 8;
    localparam logic [31:0] ADDR_DEF = 32'h0000_8000;
    localparam logic [31:0] ADDR_ALT = 32'h0000_0000;

    logic        CLOCK_50 = 1'b0;
    logic        reset_n  = 1'b0;
    logic        key      = 1'b1;
    logic        jtag     = 1'b0;
    logic        halt     = 1'b0;
    logic        sel      = 1'b0;
    logic        core_rst_n;
    logic        fetch_enable;
    logic [31:0] boot_addr;
    logic [2:0]  state;
    logic [1:0]  cause;
    logic [7:0]  count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        key;
        logic        jtag;
        logic        halt;
        logic        sel;
        int          cycles;
        logic        core;
        logic        fetch;
        logic [2:0]  st;
        logic [31:0] boot;
        logic [1:0]  cause;
        logic [7:0]  count;
    } vec_t;

    pulpino_boot_ctrl #(
        .BOOT_ADDR_DEFAULT  (ADDR_DEF),
        .BOOT_ADDR_ALT      (ADDR_ALT),
        .DEBOUNCE_CYCLES    (DEB),
        .RESET_HOLD_CYCLES  (HOLD),
        .FETCH_DELAY_CYCLES (FETCH)
    ) dut (
        .CLOCK_50       (CLOCK_50),
        .reset_n        (reset_n),
        .key_rst_n_i    (key),
        .jtag_reset_i   (jtag),
        .halt_req_i     (halt),
        .boot_sel_i     (sel),
        .core_rst_n_o   (core_rst_n),
        .fetch_enable_o (fetch_enable),
        .boot_addr_o    (boot_addr),
        .state_o        (state),
        .reset_cause_o  (cause),
        .reset_count_o  (count)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Reference model: inputs reach the logic through delay lines, the button
    // is accepted after DEB disagreeing samples, and each phase counts down.
    logic jq[$];
    logic hq[$];
    logic sq[$];
    logic kq[$];
    logic        m_deb;
    logic        m_btn;
    logic        m_first;
    int          m_run;
    int          m_left;
    int          m_phase;
    logic [31:0] m_boot;
    logic [1:0]  m_cause;
    int          m_count;

    always @(posedge CLOCK_50 or negedge reset_n) begin
        logic js, hs, ss, ks, rq_btn, rq;
        if (!reset_n) begin
            jq      = '{1'b0, 1'b0, 1'b0};
            hq      = '{1'b0, 1'b0};
            sq      = '{1'b0, 1'b0};
            kq      = '{1'b1, 1'b1};
            m_deb   = 1'b1;
            m_btn   = 1'b0;
            m_first = 1'b1;
            m_run   = 0;
            m_left  = HOLD;
            m_phase = 0;
            m_boot  = ADDR_DEF;
            m_cause = 2'd0;
            m_count = 0;
        end else begin
            js = jq.pop_front(); jq.push_back(jtag);
            hs = hq.pop_front(); hq.push_back(halt);
            ss = sq.pop_front(); sq.push_back(sel);
            ks = kq.pop_front(); kq.push_back(key);
            rq_btn = m_btn;
            m_btn  = ~m_deb;
            if (ks !== m_deb) begin
                m_run++;
                if (m_run == DEB) begin
                    m_deb = ks;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            rq      = m_first | js | rq_btn;
            m_first = 1'b0;
            if (m_phase == 0) begin
                if (rq) begin
                    m_left = HOLD;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_phase = 1;
                        m_left  = FETCH;
                        m_boot  = ss ? ADDR_ALT : ADDR_DEF;
                    end
                end
            end else if (rq) begin
                m_phase = 0;
                m_left  = HOLD;
                m_cause = js ? 2'd2 : 2'd1;
                if (m_count < 255) m_count++;
            end else if (m_phase == 1) begin
                m_left--;
                if (m_left == 0) m_phase = 2;
            end else if (m_phase == 2 && hs) begin
                m_phase = 3;
            end else if (m_phase == 3 && !hs) begin
                m_phase = 2;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic k, input logic j, input logic h, input logic s);
        key  = k;
        jtag = j;
        halt = h;
        sel  = s;
    endtask

    task automatic tick();
        @(negedge CLOCK_50);
        if (reset_n) begin
            checkOutput("mdl_core",  32'(core_rst_n),   32'(m_phase != 0));
            checkOutput("mdl_fetch", 32'(fetch_enable), 32'(m_phase == 2));
            checkOutput("mdl_state", 32'(state),        32'(m_phase));
            checkOutput("mdl_boot",  boot_addr,         m_boot);
            checkOutput("mdl_cause", 32'(cause),        32'(m_cause));
            checkOutput("mdl_count", 32'(count),        32'(m_count));
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_core"},  32'(core_rst_n),   32'd0);
        checkOutput({tag, "_fetch"}, 32'(fetch_enable), 32'd0);
        checkOutput({tag, "_state"}, 32'(state),        32'd0);
        checkOutput({tag, "_boot"},  boot_addr,         ADDR_DEF);
        checkOutput({tag, "_cause"}, 32'(cause),        32'd0);
        checkOutput({tag, "_count"}, 32'(count),        32'd0);
    endtask

    initial begin
        vec_t vecs[9];
        logic rk, rj, rh;
        bit   found;

        // Starting from RUN after a POR with boot_sel = 0.
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1,   5, 1'b1, 1'b1, 3'd2, ADDR_DEF, 2'd0, 8'd0};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b1,   4, 1'b1, 1'b0, 3'd3, ADDR_DEF, 2'd0, 8'd0};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b1,   4, 1'b1, 1'b1, 3'd2, ADDR_DEF, 2'd0, 8'd0};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1,  10, 1'b0, 1'b0, 3'd0, ADDR_DEF, 2'd1, 8'd1};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1,  10, 1'b0, 1'b0, 3'd0, ADDR_DEF, 2'd1, 8'd1};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1,  30, 1'b1, 1'b1, 3'd2, ADDR_ALT, 2'd1, 8'd1};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b1,  12, 1'b0, 1'b0, 3'd0, ADDR_ALT, 2'd2, 8'd2};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 100, 1'b0, 1'b0, 3'd0, ADDR_ALT, 2'd2, 8'd2};
        vecs[8] = '{1'b1, 1'b0, 1'b0, 1'b0,  40, 1'b1, 1'b1, 3'd2, ADDR_DEF, 2'd2, 8'd2};

        // Power-on: core reset rises on edge 17, fetch enable on edge 25.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        checkResetValues("por_in_reset");
        reset_n = 1'b1;
        repeat (HOLD) tick();
        checkOutput("por_core_edge16", 32'(core_rst_n), 32'd0);
        tick();
        checkOutput("por_core_edge17", 32'(core_rst_n), 32'd1);
        repeat (FETCH - 1) tick();
        checkOutput("por_fetch_edge24", 32'(fetch_enable), 32'd0);
        tick();
        checkOutput("por_fetch_edge25", 32'(fetch_enable), 32'd1);
        checkOutput("por_boot",  boot_addr,   ADDR_DEF);
        checkOutput("por_cause", 32'(cause),  32'd0);
        checkOutput("por_count", 32'(count),  32'd0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].key, vecs[i].jtag, vecs[i].halt, vecs[i].sel);
            repeat (vecs[i].cycles) tick();
            checkOutput($sformatf("vec%0d_core", i),  32'(core_rst_n),   32'(vecs[i].core));
            checkOutput($sformatf("vec%0d_fetch", i), 32'(fetch_enable), 32'(vecs[i].fetch));
            checkOutput($sformatf("vec%0d_state", i), 32'(state),        32'(vecs[i].st));
            checkOutput($sformatf("vec%0d_boot", i),  boot_addr,         vecs[i].boot);
            checkOutput($sformatf("vec%0d_cause", i), 32'(cause),        32'(vecs[i].cause));
            checkOutput($sformatf("vec%0d_count", i), 32'(count),        32'(vecs[i].count));
        end

        // Halt: fetch enable drops on the third edge, core stays out of reset.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (2) tick();
        checkOutput("halt_fetch_edge2", 32'(fetch_enable), 32'd1);
        tick();
        checkOutput("halt_fetch_edge3", 32'(fetch_enable), 32'd0);
        checkOutput("halt_core",        32'(core_rst_n),   32'd1);
        checkOutput("halt_state",       32'(state),        32'd3);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        checkOutput("resume_fetch", 32'(fetch_enable), 32'd1);
        checkOutput("resume_state", 32'(state),        32'd2);

        // Boot select latched at release only.
        reset_n = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge CLOCK_50);
        reset_n = 1'b1;
        repeat (30) tick();
        checkOutput("bsel_boot_alt", boot_addr,  ADDR_ALT);
        checkOutput("bsel_state",    32'(state), 32'd2);
        checkOutput("bsel_count",    32'(count), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (10) tick();
        checkOutput("bsel_boot_kept", boot_addr,  ADDR_ALT);
        checkOutput("bsel_run_kept",  32'(state), 32'd2);

        // Single-cycle button glitches must not cause a reset.
        repeat (5) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
            tick();
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
            repeat (3) tick();
        end
        repeat (10) tick();
        checkOutput("glitch_state", 32'(state),      32'd2);
        checkOutput("glitch_core",  32'(core_rst_n), 32'd1);
        checkOutput("glitch_count", 32'(count),      32'd0);

        rk = 1'b1; rj = 1'b0; rh = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (rj) begin
                if ($urandom_range(0, 3) == 0) rj = 1'b0;
            end else if ($urandom_range(0, 79) == 0) begin
                rj = 1'b1;
            end
            if ($urandom_range(0, 39) == 0) rk = ~rk;
            if ($urandom_range(0, 29) == 0) rh = ~rh;
            applyStimulus(rk, rj, rh, 1'($urandom_range(0, 1)));
            tick();
        end

        // Saturation: every JTAG pulse lands outside HOLD.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (40) tick();
        repeat (260) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
            repeat (2) tick();
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
            repeat (20) tick();
        end
        checkOutput("sat_count", 32'(count), 32'd255);
        checkOutput("sat_cause", 32'(cause), 32'd2);

        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (state == 3'd1) found = 1'b1;
            else tick();
        end
        checkOutput("release_reached", 32'(found), 32'd1);
        #5;
        reset_n = 1'b0;
        #1;
        checkResetValues("async_reset");
        @(negedge CLOCK_50);
        reset_n = 1'b1;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
